// File: rtl/lsu_mem_access.sv
// Memory-stage load/store unit: sizes and aligns requests, runs the request/grant/response
// bus handshake with a timeout, and formats load data back for the pipeline.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_swhb,
  input  logic        req_unsigned,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  size_e             size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  size_e       req_size;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_al;
  logic        req_misalign;

  // Request decode: size, byte enables, lane replication and alignment check.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    req_size     = SZ_WORD;
    req_be       = 4'b1111;
    req_wdata_al = req_wdata;
    req_misalign = 1'b0;
    case (req_swhb)
      2'b10: req_size = SZ_HALF;
      2'b11: req_size = SZ_BYTE;
      default: req_size = SZ_WORD;
    endcase
    case (req_size)
      SZ_HALF: begin
        req_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_al = {2{req_wdata[15:0]}};
        req_misalign = req_addr[0];
      end
      SZ_BYTE: begin
        req_be       = 4'b0001 << req_addr[1:0];
        req_wdata_al = {4{req_wdata[7:0]}};
      end
      default: begin
        req_misalign = (req_addr[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !req_misalign) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          be_d    = req_be;
          wdata_d = req_wdata_al;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          // Each phase gets its own timeout budget.
          cnt_d = '0;
          if (we_q) begin
            state_d = S_DONE;
          end else if (mem_rvalid) begin
            rdata_d = mem_rdata;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the captured request registers are reset too, so bus outputs start at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= SZ_WORD;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  logic [31:0] lane_shifted;
  logic [31:0] load_fmt;

  always_comb begin
    lane_shifted = rdata_q >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: load_fmt = {{24{lane_shifted[7] & ~uns_q}}, lane_shifted[7:0]};
      SZ_HALF: load_fmt = addr_q[1] ? {{16{rdata_q[31] & ~uns_q}}, rdata_q[31:16]}
                                    : {{16{rdata_q[15] & ~uns_q}}, rdata_q[15:0]};
      default: load_fmt = rdata_q;
    endcase
  end

  logic in_idle, in_req, in_wait, in_done;
  assign in_idle = (state_q == S_IDLE);
  assign in_req  = (state_q == S_REQ);
  assign in_wait = (state_q == S_WAIT);
  assign in_done = (state_q == S_DONE);

  // Outputs that depend on live request inputs are gated so reset silences them at once.
  assign misalign   = ~reset & in_idle & req_valid & req_misalign;
  assign stall      = ~reset & ((in_idle & req_valid & ~req_misalign) | in_req | in_wait);
  assign resp_valid = ~reset & (in_done | misalign);
  assign bus_err    = ~reset & in_done & err_q;
  assign resp_rdata = (~reset & in_done & ~we_q) ? load_fmt : 32'h0;

  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be    = in_req ? be_q : 4'h0;
  assign mem_wdata = in_req ? wdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboarded random + directed bench for lsu_mem_access with a small bus responder.
module tb_lsu_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_swhb;
  logic        stall, resp_valid, misalign, bus_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_access #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_swhb(req_swhb), .req_unsigned(req_unsigned),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain arithmetic on access size in bytes.
  function automatic int size_bytes(input logic [1:0] swhb);
    if (swhb == 2'b11) return 1;
    if (swhb == 2'b10) return 2;
    return 4;
  endfunction

  function automatic logic is_mis(input logic [31:0] addr, input logic [1:0] swhb);
    return (addr % size_bytes(swhb)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] swhb);
    int sz = size_bytes(swhb);
    if (sz == 4) return 4'hF;
    if (sz == 2) return 4'(3 << (addr % 4));
    return 4'(1 << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] swhb);
    int sz = size_bytes(swhb);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                             input logic [1:0] swhb, input logic uns);
    int          sz = size_bytes(swhb);
    logic [31:0] v;
    if (sz == 4) return rd;
    v = rd >> (8 * (addr % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One access, cycle n=0 is the cycle the request is first presented.
  // gd: REQ cycles before grant; rd: cycles from grant to rvalid (0 = same cycle);
  // ng/nr: grant/rvalid never arrive.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] swhb, input logic uns, input int gd, input int rd,
                        input logic ng, input logic nr, input logic [31:0] rdv);
    int   gcyc, rcyc, resp_idx, req_end;
    logic mis;
    exp_t e;
    mis  = is_mis(addr, swhb);
    gcyc = 1 + gd;
    rcyc = gcyc + rd;
    if (mis) begin
      resp_idx = 0; req_end = 0;
    end else if (ng) begin
      resp_idx = 1 + TMO; req_end = TMO;
    end else begin
      req_end = gcyc;
      if (we) resp_idx = gcyc + 1;
      else if (nr) resp_idx = gcyc + TMO + 1;
      else if (rd == 0) resp_idx = gcyc + 1;
      else resp_idx = rcyc + 1;
    end
    e.mis   = mis;
    e.err   = !mis && (ng || (!we && nr));
    e.rdata = (mis || we || e.err) ? 32'h0 : model_load(rdv, addr, swhb, uns);
    sb.push_back(e);

    for (int n = 0; n <= resp_idx; n++) begin
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wd;
      req_swhb     = swhb;
      req_unsigned = uns;
      mem_gnt      = !mis && !ng && (n == gcyc);
      mem_rvalid   = !mis && !ng && !we && !nr && (n == rcyc);
      mem_rdata    = mem_rvalid ? rdv : $urandom();
      @(negedge clk);
      check("stall", stall, (n < resp_idx));
      check("resp_valid", resp_valid, (n == resp_idx));
      check("misalign", misalign, (mis && n == 0));
      check("mem_req", mem_req, (n >= 1 && n <= req_end));
      if (n >= 1 && n <= req_end) begin
        check("mem_we", mem_we, we);
        check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("mem_be", mem_be, model_be(addr, swhb));
        check("mem_wdata", mem_wdata, model_wdata(wd, swhb));
      end
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // Monitor: every response the DUT presents is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", resp_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("bus_err", bus_err, e.err);
          check("resp_misalign", misalign, e.mis);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, w, r;
    logic [1:0]  s;
    int          sz;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_swhb = '0; req_unsigned = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_misalign", misalign, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed cases.
    access(1'b1, 32'h8000_0003, 32'h0000_00A5, 2'b11, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);
    access(1'b0, 32'h8000_0006, 32'h0, 2'b10, 1'b0, 0, 1, 1'b0, 1'b0, 32'h8001_1234);
    access(1'b0, 32'h8000_0006, 32'h0, 2'b10, 1'b1, 0, 1, 1'b0, 1'b0, 32'h8001_1234);
    access(1'b0, 32'h8000_0008, 32'h0, 2'b01, 1'b0, 3, 2, 1'b0, 1'b0, 32'hDEAD_BEEF);
    access(1'b0, 32'h8000_0002, 32'h0, 2'b01, 1'b0, 0, 1, 1'b0, 1'b0, 32'h0);
    access(1'b1, 32'h8000_0010, 32'h1234_5678, 2'b00, 1'b0, 0, 0, 1'b1, 1'b0, 32'h0);
    access(1'b0, 32'h8000_0021, 32'h0, 2'b11, 1'b0, 1, 1, 1'b0, 1'b0, 32'h0000_F000);
    access(1'b0, 32'h8000_0014, 32'h0, 2'b01, 1'b0, 1, 0, 1'b0, 1'b1, 32'h0);
    access(1'b0, 32'h8000_0032, 32'h0, 2'b10, 1'b0, 2, 0, 1'b0, 1'b0, 32'hC0DE_7FFF);
    access(1'b0, 32'h8000_0040, 32'h0, 2'b01, 1'b0, 0, 0, 1'b1, 1'b0, 32'h0);
    access(1'b1, 32'h8000_0046, 32'hABCD_9876, 2'b10, 1'b0, 3, 0, 1'b0, 1'b0, 32'h0);

    // Reset during WAIT: everything silent immediately, late rvalid ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0050; req_swhb = 2'b01;
    req_unsigned = 1'b0;
    @(posedge clk); #1 mem_gnt = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b0;
    check("wait_stall", stall, 1);
    #2 reset = 1'b1;
    #1;
    check("rstw_mem_req", mem_req, 0);
    check("rstw_stall", stall, 0);
    check("rstw_resp_valid", resp_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("late_rvalid_resp", resp_valid, 0);
      check("late_rvalid_stall", stall, 0);
    end
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      s  = 2'($urandom_range(0, 3));
      sz = size_bytes(s);
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
      w  = $urandom();
      r  = $urandom();
      access(1'($urandom_range(0, 1)), a, w, s, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, TMO),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), r);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Memory-stage load/store unit between the EX/MEM pipeline register and the data-memory bus.
- Accepts one load or store per pipeline request and derives byte enables from access size and address.
- Aligns store data onto byte lanes, runs a multi-cycle request/grant/response handshake, then extracts and sign- or zero-extends load data.
- Stalls the pipeline until the access completes, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum cycles waited in REQ or WAIT before the access is aborted as a bus error.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage holds a load or store
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_swhb  in  2  access size: 01 word, 10 half, 11 byte; 00 is treated as word
- req_unsigned  in  1  load zero-extends (LBU/LHU)
- stall  out  1  freezes the pipeline; the request must be held stable while this is high
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  formatted load data, valid with resp_valid; 0 for stores
- misalign  out  1  one-cycle pulse for a misaligned request
- bus_err  out  1  one-cycle pulse on timeout, coincident with resp_valid
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address, {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_gnt  in  1  bus accepted the request this cycle
- mem_rvalid  in  1  read data valid this cycle
- mem_rdata  in  32  read data

Behaviour:
- Reset state:
  - All outputs 0; state IDLE; counter 0.
  - Reset asserted mid-access drops mem_req immediately (asynchronous), discards the access and issues no response.
- States: IDLE, REQ, WAIT, DONE.
- Byte enables:
  - word: 1111
  - half: 1100 if addr[1], else 0011
  - byte: one-hot at addr[1:0] (00→0001 … 11→1000)
- Store data alignment:
  - byte: the low byte is replicated to all 4 lanes.
  - half: the low half is replicated to both halves.
  - word: passed through unchanged.
- Misalignment:
  - A word access with addr[1:0]≠00, or a half access with addr[0]=1, is misaligned.
  - In IDLE, such a request pulses misalign and resp_valid in the same cycle, with resp_rdata=0 and stall=0.
  - No bus access is made and the state stays IDLE.
- IDLE, aligned request:
  - stall=1 combinationally.
  - Registers the address, size, we, unsigned, be and aligned wdata.
  - Next state REQ; counter cleared.
- REQ:
  - mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata driven from the captured registers and held stable until grant.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT. mem_req drops in the following cycle.
  - The counter increments each cycle without grant; reaching TIMEOUT forces DONE with bus_err pending.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: capture mem_rdata and go to DONE.
  - mem_rvalid arriving in the same cycle as mem_gnt (still in REQ) is also captured, and the state goes directly to DONE.
  - The counter runs as in REQ; a timeout goes to DONE with rdata=0 and bus_err pending.
- DONE:
  - resp_valid=1, stall=0, bus_err as pending; next state IDLE.
  - req_valid in DONE is ignored, because the pipeline is still presenting the completed request this cycle.
- Load formatting (lane selected by the captured addr):
  - byte: lane addr[1:0], bit 7 sign-extended unless unsigned.
  - half: lane addr[1], bit 15 sign-extended unless unsigned.
  - word: passed through unchanged.
- stall = (IDLE & req_valid & aligned) | REQ | WAIT.
- Latency with zero-wait memory (gnt in the first REQ cycle, rvalid the next cycle):
  - store: 3 cycles, IDLE→REQ→DONE.
  - load: 4 cycles.

Test Plan:
- Store byte: addr 0x80000003, wdata 0x000000A5, swhb 11, gnt immediate → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x80000000; resp_valid on the 3rd cycle; stall high for 2 cycles.
- Load half, signed vs unsigned: addr 0x80000006, mem_rdata 0x8001_1234 → signed gives resp_rdata=0xFFFF8001; unsigned gives 0x00008001.
- Wait states: gnt after 3 cycles, rvalid after 2 more, word load of 0xDEADBEEF → mem_req stable for 4 cycles; resp_rdata=0xDEADBEEF; stall deasserts in DONE.
- Misaligned word load at 0x80000002 → misalign=1 and resp_valid=1 in the same cycle; mem_req never asserted; stall=0.
- Timeout with TIMEOUT=4 and gnt never asserted → mem_req high for 4 cycles, then resp_valid=1, bus_err=1, resp_rdata=0; the next request is accepted normally.
- Reset asserted during WAIT → mem_req, stall and resp_valid are 0 immediately; a late mem_rvalid after reset produces no response.
